// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 control: FETCH/DECODE/EXEC/MEM/WB/BRANCH sequencer with memory timeout,
// sticky illegal/fault flags and a retired-instruction counter. Outputs are Moore except pc_branch.
module multicycle_control #(
    parameter int OP_WIDTH    = 11,
    parameter int CNT_WIDTH   = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [OP_WIDTH-1:0]  op,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 ir_write,
    output logic                 pc_inc,
    output logic                 pc_branch,
    output logic [1:0]           ALUOp,
    output logic                 ALUSrc,
    output logic                 Branch,
    output logic                 UncondBranch,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 RegWrite,
    output logic                 MemtoReg,
    output logic                 illegal,
    output logic                 mem_fault,
    output logic [2:0]           state,
    output logic [CNT_WIDTH-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_BRANCH = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_NONE = 3'd0,
        C_R    = 3'd1,
        C_LDUR = 3'd2,
        C_STUR = 3'd3,
        C_CBZ  = 3'd4,
        C_B    = 3'd5,
        C_ILL  = 3'd6
    } class_t;

    localparam logic [7:0] L_TIMEOUT = 8'(MEM_TIMEOUT);

    state_t               r_state;
    class_t               r_class;
    logic [7:0]           r_wait;
    logic                 r_illegal;
    logic                 r_fault;
    logic [CNT_WIDTH-1:0] r_retired;

    state_t     w_next;
    class_t     w_dec_class;
    logic [10:0] w_op11;
    logic [7:0] w_wait_nxt;
    logic       w_retire;
    logic       w_set_ill;
    logic       w_set_fault;
    logic       w_wait_clr;
    logic       w_wait_inc;

    logic       w_ir_write;
    logic       w_pc_inc;
    logic       w_pc_branch;
    logic [1:0] w_aluop;
    logic       w_alusrc;
    logic       w_branch;
    logic       w_uncond;
    logic       w_memread;
    logic       w_memwrite;
    logic       w_regwrite;
    logic       w_memtoreg;

    assign w_op11     = op[OP_WIDTH-1 -: 11];
    assign w_wait_nxt = r_wait + 8'd1;

    always_comb begin
        w_dec_class = C_ILL;
        casez (w_op11)
            11'b10001011000,
            11'b11001011000,
            11'b10001010000,
            11'b10101010000: w_dec_class = C_R;
            11'b11111000010: w_dec_class = C_LDUR;
            11'b11111000000: w_dec_class = C_STUR;
            11'b10110100???: w_dec_class = C_CBZ;
            11'b000101?????: w_dec_class = C_B;
            default:         w_dec_class = C_ILL;
        endcase
    end

    always_comb begin
        w_next      = r_state;
        w_retire    = 1'b0;
        w_set_ill   = 1'b0;
        w_set_fault = 1'b0;
        w_wait_clr  = 1'b0;
        w_wait_inc  = 1'b0;
        w_ir_write  = 1'b0;
        w_pc_inc    = 1'b0;
        w_pc_branch = 1'b0;
        w_aluop     = 2'b00;
        w_alusrc    = 1'b0;
        w_branch    = 1'b0;
        w_uncond    = 1'b0;
        w_memread   = 1'b0;
        w_memwrite  = 1'b0;
        w_regwrite  = 1'b0;
        w_memtoreg  = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ir_write = 1'b1;
                w_pc_inc   = 1'b1;
                w_next     = S_DECODE;
            end
            S_DECODE: begin
                case (w_dec_class)
                    C_R, C_LDUR, C_STUR: w_next = S_EXEC;
                    C_CBZ, C_B:          w_next = S_BRANCH;
                    default: begin
                        w_next    = S_TRAP;
                        w_set_ill = 1'b1;
                    end
                endcase
            end
            S_EXEC: begin
                if (r_class == C_R) begin
                    w_aluop = 2'b10;
                    w_next  = S_WB;
                end else begin
                    w_alusrc   = 1'b1;
                    w_wait_clr = 1'b1;
                    w_next     = S_MEM;
                end
            end
            S_MEM: begin
                w_alusrc   = 1'b1;
                w_memread  = (r_class == C_LDUR);
                w_memwrite = (r_class == C_STUR);
                // A completion on the last allowed cycle beats the timeout.
                if (mem_ready) begin
                    if (r_class == C_LDUR) begin
                        w_next = S_WB;
                    end else begin
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                    end
                end else if (w_wait_nxt == L_TIMEOUT) begin
                    w_next      = S_TRAP;
                    w_set_fault = 1'b1;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end
            S_WB: begin
                w_regwrite = 1'b1;
                w_memtoreg = (r_class == C_LDUR);
                w_next     = S_FETCH;
                w_retire   = 1'b1;
            end
            S_BRANCH: begin
                if (r_class == C_CBZ) begin
                    w_branch    = 1'b1;
                    w_aluop     = 2'b01;
                    w_pc_branch = zero;
                end else begin
                    w_uncond    = 1'b1;
                    w_pc_branch = 1'b1;
                end
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_TRAP: begin
                w_next = S_TRAP;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_class   <= C_NONE;
            r_wait    <= 8'd0;
            r_illegal <= 1'b0;
            r_fault   <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_class <= w_dec_class;
            end
            if (w_wait_clr) begin
                r_wait <= 8'd0;
            end else if (w_wait_inc) begin
                r_wait <= w_wait_nxt;
            end
            if (w_set_ill) begin
                r_illegal <= 1'b1;
            end
            if (w_set_fault) begin
                r_fault <= 1'b1;
            end
            if (w_retire) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    // The state register already reads FETCH during reset, so outputs are masked explicitly.
    assign ir_write     = w_ir_write  & ~reset;
    assign pc_inc       = w_pc_inc    & ~reset;
    assign pc_branch    = w_pc_branch & ~reset;
    assign ALUOp        = reset ? 2'b00 : w_aluop;
    assign ALUSrc       = w_alusrc    & ~reset;
    assign Branch       = w_branch    & ~reset;
    assign UncondBranch = w_uncond    & ~reset;
    assign MemRead      = w_memread   & ~reset;
    assign MemWrite     = w_memwrite  & ~reset;
    assign RegWrite     = w_regwrite  & ~reset;
    assign MemtoReg     = w_memtoreg  & ~reset;
    assign illegal      = r_illegal   & ~reset;
    assign mem_fault    = r_fault     & ~reset;
    assign state        = reset ? 3'd0 : r_state;
    assign retired      = reset ? '0 : r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized instruction stream checked cycle by cycle against a per-instruction state-sequence model.
module tb_multicycle_control;

    localparam int OPW = 11;
    localparam int CW  = 4;
    localparam int TMO = 15;

    localparam int K_R = 1, K_LDUR = 2, K_STUR = 3, K_CBZ = 4, K_B = 5, K_ILL = 6;

    logic           clk = 1'b0;
    logic           reset;
    logic [OPW-1:0] op;
    logic           zero;
    logic           mem_ready;
    logic           ir_write, pc_inc, pc_branch, ALUSrc, Branch, UncondBranch;
    logic           MemRead, MemWrite, RegWrite, MemtoReg, illegal, mem_fault;
    logic [1:0]     ALUOp;
    logic [2:0]     state;
    logic [CW-1:0]  retired;

    int n_checks = 0;
    int n_errors = 0;
    int exp_retired = 0;
    bit exp_illegal = 0;
    bit exp_fault = 0;

    multicycle_control #(.OP_WIDTH(OPW), .CNT_WIDTH(CW), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .ir_write(ir_write), .pc_inc(pc_inc), .pc_branch(pc_branch), .ALUOp(ALUOp),
        .ALUSrc(ALUSrc), .Branch(Branch), .UncondBranch(UncondBranch),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .illegal(illegal), .mem_fault(mem_fault), .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int classify(input logic [10:0] o);
        if (o == 11'b10001011000 || o == 11'b11001011000 ||
            o == 11'b10001010000 || o == 11'b10101010000) return K_R;
        if (o == 11'b11111000010) return K_LDUR;
        if (o == 11'b11111000000) return K_STUR;
        if (o ==? 11'b10110100???) return K_CBZ;
        if (o ==? 11'b000101?????) return K_B;
        return K_ILL;
    endfunction

    // Compare every output for a cycle the model says is in state s of an instruction of class k.
    task automatic check_all(input int s, input int k, input bit z, input bit in_rst);
        bit e_irw = 0, e_pci = 0, e_pcb = 0, e_src = 0, e_br = 0, e_ub = 0;
        bit e_mr = 0, e_mw = 0, e_rw = 0, e_m2r = 0;
        int e_alu = 0;
        if (!in_rst) begin
            case (s)
                0: begin e_irw = 1; e_pci = 1; end
                2: begin e_alu = (k == K_R) ? 2 : 0; e_src = (k != K_R); end
                3: begin e_src = 1; e_mr = (k == K_LDUR); e_mw = (k == K_STUR); end
                4: begin e_rw = 1; e_m2r = (k == K_LDUR); end
                5: begin
                    e_br = (k == K_CBZ); e_ub = (k == K_B);
                    e_alu = (k == K_CBZ) ? 1 : 0;
                    e_pcb = (k == K_B) || z;
                end
                default: ;
            endcase
        end
        check("state", state, in_rst ? 0 : s);
        check("ir_write", ir_write, e_irw);
        check("pc_inc", pc_inc, e_pci);
        check("pc_branch", pc_branch, e_pcb);
        check("ALUOp", ALUOp, e_alu);
        check("ALUSrc", ALUSrc, e_src);
        check("Branch", Branch, e_br);
        check("UncondBranch", UncondBranch, e_ub);
        check("MemRead", MemRead, e_mr);
        check("MemWrite", MemWrite, e_mw);
        check("RegWrite", RegWrite, e_rw);
        check("MemtoReg", MemtoReg, e_m2r);
        check("illegal", illegal, exp_illegal);
        check("mem_fault", mem_fault, exp_fault);
        check("retired", retired, exp_retired % (1 << CW));
    endtask

    task automatic randomize_inputs();
        op        = OPW'($urandom);
        zero      = 1'($urandom);
        mem_ready = 1'($urandom);
    endtask

    // Called at posedge+1; leaves the bench at posedge+1 with the DUT in FETCH.
    task automatic do_reset();
        reset = 1'b1;
        randomize_inputs();
        exp_retired = 0;
        exp_illegal = 0;
        exp_fault   = 0;
        #1;
        check_all(0, 0, zero, 1'b1);
        @(posedge clk);
        #1;
        randomize_inputs();
        check_all(0, 0, zero, 1'b1);
        reset = 1'b0;
    endtask

    // w = MEM cycles with mem_ready low before completion; w >= TMO means the access never completes.
    task automatic run_instr(input logic [10:0] op11, input int w, input bit abort_in_mem);
        int k = classify(op11);
        int st_q[$];
        int mem_idx = 0;
        bit fault = ((k == K_LDUR) || (k == K_STUR)) && (w >= TMO);
        bit trap  = (k == K_ILL) || fault;
        st_q.push_back(0);
        st_q.push_back(1);
        case (k)
            K_R: begin st_q.push_back(2); st_q.push_back(4); end
            K_LDUR, K_STUR: begin
                st_q.push_back(2);
                for (int j = 0; j < (fault ? TMO : w + 1); j++) st_q.push_back(3);
                if (k == K_LDUR && !fault) st_q.push_back(4);
            end
            K_CBZ, K_B: st_q.push_back(5);
            default: ;
        endcase
        foreach (st_q[i]) begin
            if (abort_in_mem && st_q[i] == 3) begin
                do_reset();
                return;
            end
            randomize_inputs();
            if (st_q[i] == 1) op = op11;
            if (st_q[i] == 3) begin
                mem_ready = (mem_idx == w);
                mem_idx++;
            end
            #1;
            check_all(st_q[i], k, zero, 1'b0);
            @(posedge clk);
            #1;
        end
        if (trap) begin
            if (k == K_ILL) exp_illegal = 1;
            else            exp_fault   = 1;
            for (int c = 0; c < 12; c++) begin
                randomize_inputs();
                #1;
                check_all(6, k, zero, 1'b0);
                @(posedge clk);
                #1;
            end
            do_reset();
        end else begin
            exp_retired++;
        end
    endtask

    function automatic logic [10:0] rand_op(input int sel);
        logic [10:0] r = 11'($urandom);
        case (sel)
            0: return 11'b10001011000;
            1: return 11'b11001011000;
            2: return 11'b10001010000;
            3: return 11'b10101010000;
            4: return 11'b11111000010;
            5: return 11'b11111000000;
            6: return {8'b10110100, r[2:0]};
            7: return {6'b000101, r[4:0]};
            default: return r;
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        randomize_inputs();
        @(posedge clk);
        #1;
        do_reset();

        run_instr(11'b10001011000, 0, 1'b0);
        run_instr(11'b11111000010, 2, 1'b0);
        run_instr(11'b10110100101, 0, 1'b0);
        run_instr(11'b10110100101, 0, 1'b0);

        for (int n = 0; n < 160; n++) begin
            int sel = $urandom_range(0, 9);
            int w = ($urandom_range(0, 7) == 0) ? $urandom_range(TMO - 1, TMO) : $urandom_range(0, 4);
            run_instr(rand_op(sel), w, 1'b0);
        end

        for (int n = 0; n < 16; n++) run_instr(11'b00010100000, 0, 1'b0);

        run_instr(11'b11111000000, TMO, 1'b0);
        run_instr(11'b11111000000, TMO - 1, 1'b0);
        run_instr(11'b11111000010, TMO - 1, 1'b0);
        run_instr(11'b00000000000, 0, 1'b0);
        run_instr(11'b10001011000, 0, 1'b0);
        run_instr(11'b11111000010, 3, 1'b1);
        run_instr(11'b10101010000, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
